// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fir_pkg
//  Description : Shared types and helpers for the time-multiplexed symmetric
//                FIR filter: FSM state type, accumulator width calculation,
//                and round-half-up / saturate helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package fir_pkg;

    // The round/saturate helpers work on a 64-bit signed container. Every
    // accumulator must fit in it with headroom for the rounding constant.
    localparam int c_WIDE_W = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        ROUND = 2'd2,
        OUT   = 2'd3
    } state_t;

    // Pair sum (+1 bit) times coefficient, plus growth over NTAPS/2 terms.
    function automatic int acc_width(input int data_w, input int coef_w,
                                     input int ntaps);
        return data_w + coef_w + 1 + $clog2(ntaps / 2);
    endfunction

    // Adds half an LSB of the result and shifts arithmetically: ties go up.
    function automatic logic signed [c_WIDE_W-1:0] round_half_up(
        input logic signed [c_WIDE_W-1:0] acc, input int frac);
        return (acc + (64'sd1 <<< (frac - 1))) >>> frac;
    endfunction

    function automatic logic signed [c_WIDE_W-1:0] round_sat_value(
        input logic signed [c_WIDE_W-1:0] acc, input int frac, input int out_w);
        logic signed [c_WIDE_W-1:0] r;
        logic signed [c_WIDE_W-1:0] hi;
        logic signed [c_WIDE_W-1:0] lo;
        r  = round_half_up(acc, frac);
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (r > hi) begin
            return hi;
        end
        if (r < lo) begin
            return lo;
        end
        return r;
    endfunction

    function automatic logic round_sat_flag(
        input logic signed [c_WIDE_W-1:0] acc, input int frac, input int out_w);
        logic signed [c_WIDE_W-1:0] r;
        logic signed [c_WIDE_W-1:0] hi;
        logic signed [c_WIDE_W-1:0] lo;
        r  = round_half_up(acc, frac);
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        return (r > hi) || (r < lo);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_coef_bank.sv
`default_nettype none
// ============================================================================
//  Module      : fir_coef_bank
//  Description : DEPTH x COEF_W coefficient register file. Cleared by
//                synchronous reset, one write port, one combinational read.
//  Ports       : clk, reset_n       - clock, synchronous active-low reset
//                i_we/i_waddr/i_wdata - write strobe, index, value
//                i_raddr / o_rdata  - combinational read
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_coef_bank #(
    parameter int COEF_W = 16,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_we,
    input  logic [ADDR_W-1:0]        i_waddr,
    input  logic signed [COEF_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0]        i_raddr,
    output logic signed [COEF_W-1:0] o_rdata
);

    logic signed [COEF_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/fir_sym_tdm.sv
`default_nettype none
// ============================================================================
//  Module      : fir_sym_tdm
//  Description : Time-multiplexed symmetric FIR. One multiplier folds the
//                mirrored taps (x[k] + x[NTAPS-1-k]) * h[k] over NTAPS/2
//                cycles, then rounds half-up, saturates and presents the
//                result on a valid/ready output.
//  Ports       : clk, reset_n                 - clock, sync active-low reset
//                in_valid/in_ready/in_data    - sample input handshake
//                out_valid/out_ready/out_data - filtered output handshake
//                out_sat                      - output was clipped
//                coef_we/coef_addr/coef_wdata - coefficient write (IDLE only)
//                coef_err                     - one-cycle rejected-write pulse
//                flush                        - clear delay line (IDLE only)
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_sym_tdm
    import fir_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int NTAPS  = 32,
    parameter int FRAC   = 15
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [DATA_W-1:0]      in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [DATA_W-1:0]      out_data,
    output logic                          out_sat,
    input  logic                          coef_we,
    input  logic [$clog2(NTAPS/2)-1:0]    coef_addr,
    input  logic signed [COEF_W-1:0]      coef_wdata,
    output logic                          coef_err,
    input  logic                          flush
);

    localparam int c_HALF   = NTAPS / 2;
    localparam int c_K_W    = $clog2(c_HALF);
    localparam int c_X_W    = c_K_W + 1;
    localparam int c_SUM_W  = DATA_W + 1;
    localparam int c_PROD_W = DATA_W + COEF_W + 1;
    localparam int c_ACC_W  = acc_width(DATA_W, COEF_W, NTAPS);

    state_t                    r_state;
    logic signed [DATA_W-1:0]  r_x [NTAPS];
    logic [c_K_W-1:0]          r_k;
    logic signed [c_ACC_W-1:0] r_acc;
    logic                      r_out_valid;
    logic signed [DATA_W-1:0]  r_out_data;
    logic                      r_out_sat;
    logic                      r_coef_err;

    // A coefficient write that lands in the same cycle as a sample accept is
    // parked here so the in-flight sample still sees the old value; it is
    // committed as the FSM returns to IDLE.
    logic                      r_pend_we;
    logic [c_K_W-1:0]          r_pend_addr;
    logic signed [COEF_W-1:0]  r_pend_data;

    logic                      w_idle;
    logic                      w_accept;
    logic                      w_coef_ok;
    logic                      w_out_fire;
    logic                      w_bank_we;
    logic [c_K_W-1:0]          w_bank_addr;
    logic signed [COEF_W-1:0]  w_bank_data;
    logic signed [COEF_W-1:0]  w_coef;
    logic [c_X_W-1:0]          w_idx_lo;
    logic [c_X_W-1:0]          w_idx_hi;
    logic signed [DATA_W-1:0]  w_x_lo;
    logic signed [DATA_W-1:0]  w_x_hi;
    logic signed [c_SUM_W-1:0] w_pair;
    logic signed [c_PROD_W-1:0] w_pair_ext;
    logic signed [c_PROD_W-1:0] w_coef_ext;
    logic signed [c_PROD_W-1:0] w_prod;
    logic signed [c_ACC_W-1:0] w_prod_acc;

    assign w_idle     = (r_state == IDLE);
    assign in_ready   = w_idle && !flush;
    assign w_accept   = in_ready && in_valid;
    assign w_coef_ok  = coef_we && w_idle && ({1'b0, coef_addr} < c_X_W'(c_HALF));
    assign w_out_fire = (r_state == OUT) && out_ready;

    assign w_bank_we   = (w_coef_ok && !w_accept) || (r_pend_we && w_out_fire);
    assign w_bank_addr = w_idle ? coef_addr  : r_pend_addr;
    assign w_bank_data = w_idle ? coef_wdata : r_pend_data;

    fir_coef_bank #(
        .COEF_W (COEF_W),
        .DEPTH  (c_HALF),
        .ADDR_W (c_K_W)
    ) u_coef_bank (
        .clk     (clk),
        .reset_n (reset_n),
        .i_we    (w_bank_we),
        .i_waddr (w_bank_addr),
        .i_wdata (w_bank_data),
        .i_raddr (r_k),
        .o_rdata (w_coef)
    );

    // Symmetric fold: tap k and its mirror share one coefficient.
    assign w_idx_lo = {1'b0, r_k};
    assign w_idx_hi = c_X_W'(NTAPS - 1) - w_idx_lo;
    assign w_x_lo   = r_x[w_idx_lo];
    assign w_x_hi   = r_x[w_idx_hi];
    assign w_pair   = $signed({w_x_lo[DATA_W-1], w_x_lo}) + $signed({w_x_hi[DATA_W-1], w_x_hi});

    // Operands are widened to the full product width so the multiply is exact.
    assign w_pair_ext = $signed({{(c_PROD_W-c_SUM_W){w_pair[c_SUM_W-1]}}, w_pair});
    assign w_coef_ext = $signed({{(c_PROD_W-COEF_W){w_coef[COEF_W-1]}}, w_coef});
    assign w_prod     = w_pair_ext * w_coef_ext;
    assign w_prod_acc = $signed({{(c_ACC_W-c_PROD_W){w_prod[c_PROD_W-1]}}, w_prod});

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            for (int i = 0; i < NTAPS; i++) begin
                r_x[i] <= '0;
            end
            r_k         <= '0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
            r_coef_err  <= 1'b0;
            r_pend_we   <= 1'b0;
            r_pend_addr <= '0;
            r_pend_data <= '0;
        end else begin
            r_coef_err <= coef_we && !w_coef_ok;
            case (r_state)
                IDLE: begin
                    if (flush) begin
                        for (int i = 0; i < NTAPS; i++) begin
                            r_x[i] <= '0;
                        end
                    end else if (in_valid) begin
                        r_x[0] <= in_data;
                        for (int i = 1; i < NTAPS; i++) begin
                            r_x[i] <= r_x[i-1];
                        end
                        r_acc   <= '0;
                        r_k     <= '0;
                        r_state <= MAC;
                        if (w_coef_ok) begin
                            r_pend_we   <= 1'b1;
                            r_pend_addr <= coef_addr;
                            r_pend_data <= coef_wdata;
                        end
                    end
                end
                MAC: begin
                    r_acc <= r_acc + w_prod_acc;
                    r_k   <= r_k + c_K_W'(1);
                    if (r_k == c_K_W'(c_HALF - 1)) begin
                        r_state <= ROUND;
                    end
                end
                ROUND: begin
                    r_out_data  <= DATA_W'(round_sat_value(64'(r_acc), FRAC, DATA_W));
                    r_out_sat   <= round_sat_flag(64'(r_acc), FRAC, DATA_W);
                    r_out_valid <= 1'b1;
                    r_state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_pend_we   <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sat   = r_out_sat;
    assign coef_err  = r_coef_err;

endmodule
`default_nettype wire
